posit_decoder: RTL

POSIT_DECODER -- requirements
Module: posit_decoder

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_abs.sv | 32 +++
 rtl/posit_decoder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
//
// Purpose : Shared constants and types for the posit<32,4> field decoder.
//
// Contents:
//   POSIT_N     - posit word width (32)
//   POSIT_ES    - exponent field width (4)
//   FRAC_W      - widest possible fraction field (32 - sign - 2-bit regime - es)
//   K_W         - signed regime value width
//   SCALE_W     - signed combined scale (16*k + exp) width
//   M_W         - width of the regime run-length counter (run length 1..31)
//   dec_state_e - decoder control states
// -----------------------------------------------------------------------------
package posit_pkg;

    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;
    localparam int FRAC_W   = 25;
    localparam int K_W      = 6;
    localparam int SCALE_W  = 10;
    localparam int M_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a word, in_ready high
        ST_SCAN = 2'd1,   // walking the regime run, one bit per cycle
        ST_PACK = 2'd2,   // extracting exponent and fraction after the terminator
        ST_HOLD = 2'd3    // presenting decoded fields until the consumer takes them
    } dec_state_e;

endpackage : posit_pkg

// File: rtl/posit_abs.sv
// -----------------------------------------------------------------------------
// posit_abs
//
// Purpose : Combinational conditional two's complement of a posit word.
//           y = neg ? -a : a
//
// Ports:
//   a   in  [POSIT_N-1:0]  word to condition
//   neg in  1              negate when high
//   y   out [POSIT_N-1:0]  result
// -----------------------------------------------------------------------------
module posit_abs
    import posit_pkg::*;
(
    input  logic [POSIT_N-1:0] a,
    input  logic               neg,
    output logic [POSIT_N-1:0] y
);

    logic [POSIT_N-1:0] inv;

    // Ones' complement under control of neg, then add neg to finish negation.
    genvar gi;
    generate
        for (gi = 0; gi < POSIT_N; gi++) begin : g_inv
            assign inv[gi] = a[gi] ^ neg;
        end
    endgenerate

    assign y = inv + {{(POSIT_N-1){1'b0}}, neg};

endmodule : posit_abs

// File: rtl/posit_decoder.sv
// -----------------------------------------------------------------------------
// posit_decoder
//
// Purpose : Sequential decoder that splits a posit<32,4> word into sign, regime
//           value k, exponent and MSB-aligned fraction. The regime run is
//           walked one bit per cycle, so latency depends on the run length m:
//           m+2 cycles from accept to out_valid for ordinary words, 1 cycle for
//           zero and NaR.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   in_valid      in   in_data valid
//   in_ready      out  decoder idle; word accepted when in_valid && in_ready
//   in_data       in   [31:0] posit word
//   out_valid     out  decoded fields valid (held until out_ready)
//   out_ready     in   consumer accepts when out_valid && out_ready
//   out_sign      out  posit sign bit
//   out_zero      out  input was 0x00000000
//   out_nar       out  input was 0x80000000
//   out_k         out  [5:0] signed regime value
//   out_exp       out  [3:0] exponent field (missing low bits are zero)
//   out_frac      out  [24:0] fraction bits, MSB-aligned, zero-padded
//   out_scale     out  [9:0] signed 16*k + exp (only with POSIT_DEC_SCALE_EN)
//   out_frac_len  out  [4:0] number of valid fraction bits, 0..25
//
// Build option:
//   POSIT_DEC_SCALE_EN - when defined, adds the out_scale port and its logic.
// -----------------------------------------------------------------------------
module posit_decoder
    import posit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [POSIT_N-1:0]        in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic                      out_zero,
    output logic                      out_nar,
    output logic signed [K_W-1:0]     out_k,
    output logic [POSIT_ES-1:0]       out_exp,
    output logic [FRAC_W-1:0]         out_frac,
`ifdef POSIT_DEC_SCALE_EN
    output logic signed [SCALE_W-1:0] out_scale,
`endif
    output logic [4:0]                out_frac_len
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    dec_state_e          state_q, state_d;
    logic [M_W-1:0]      m_q, m_d;          // regime run length / scan counter
    logic [30:0]         body_q, body_d;    // magnitude; bit 31 is always 0 here
    logic                sign_q, sign_d;    // captured sign for ordinary words

    logic                out_sign_q, out_sign_d;
    logic                out_zero_q, out_zero_d;
    logic                out_nar_q, out_nar_d;
    logic [K_W-1:0]      out_k_q, out_k_d;
    logic [POSIT_ES-1:0] out_exp_q, out_exp_d;
    logic [FRAC_W-1:0]   out_frac_q, out_frac_d;
    logic [4:0]          out_frac_len_q, out_frac_len_d;
`ifdef POSIT_DEC_SCALE_EN
    logic [SCALE_W-1:0]  out_scale_q, out_scale_d;
`endif

    // -------------------------------------------------------------------------
    // Magnitude of the incoming word
    // -------------------------------------------------------------------------
    logic [POSIT_N-1:0] abs_y;
    logic               is_zero;
    logic               is_nar;

    posit_abs u_abs (
        .a   (in_data),
        .neg (in_data[POSIT_N-1]),
        .y   (abs_y)
    );

    assign is_zero = (in_data == '0);
    // Negating a negative word leaves bit 31 set only for 0x80000000, the one
    // value whose negation overflows, so the top bit of the magnitude flags NaR.
    assign is_nar  = abs_y[POSIT_N-1];

    // -------------------------------------------------------------------------
    // Scan and pack helpers
    // -------------------------------------------------------------------------
    logic [4:0]         scan_idx;     // body bit examined this SCAN cycle
    logic               scan_bit;
    logic [28:0]        tail;         // bits after the terminator, MSB at [28]
    logic [K_W-1:0]     k_val;
    logic [4:0]         frac_len_val;

    assign scan_idx = 5'd30 - m_q;
    assign scan_bit = body_q[scan_idx];

    // With run length m the terminator sits at bit 30-m, so the first bit after
    // it is 29-m; shifting body[28:0] left by m-1 brings that bit to [28]. A
    // run that reached bit 0 shifts everything out, giving all-zero fields.
    assign tail = body_q[28:0] << (m_q - 5'd1);

    // Run of ones: k = m-1; run of zeros: k = -m.
    assign k_val = body_q[30] ? ({1'b0, m_q} - 6'd1) : (6'd0 - {1'b0, m_q});

    // Bits below the terminator number 30-m; four of them are exponent.
    assign frac_len_val = (m_q < 5'd26) ? (5'd26 - m_q) : 5'd0;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        body_d         = body_q;
        sign_d         = sign_q;
        out_sign_d     = out_sign_q;
        out_zero_d     = out_zero_q;
        out_nar_d      = out_nar_q;
        out_k_d        = out_k_q;
        out_exp_d      = out_exp_q;
        out_frac_d     = out_frac_q;
        out_frac_len_d = out_frac_len_q;
`ifdef POSIT_DEC_SCALE_EN
        out_scale_d    = out_scale_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[POSIT_N-1];
                    body_d = abs_y[30:0];
                    if (is_zero || is_nar) begin
                        // Specials skip the scan and are presented at once.
                        m_d            = '0;
                        out_sign_d     = is_nar;
                        out_zero_d     = is_zero;
                        out_nar_d      = is_nar;
                        out_k_d        = '0;
                        out_exp_d      = '0;
                        out_frac_d     = '0;
                        out_frac_len_d = '0;
`ifdef POSIT_DEC_SCALE_EN
                        out_scale_d    = '0;
`endif
                        state_d        = ST_HOLD;
                    end else begin
                        // body[30] itself is the first bit of the run.
                        m_d     = 5'd1;
                        state_d = ST_SCAN;
                    end
                end
            end

            ST_SCAN: begin
                // m == 31 means bits 29..0 all matched; that costs one final
                // cycle here so the scan always lasts exactly m cycles.
                if (m_q == 5'd31 || scan_bit != body_q[30]) begin
                    state_d = ST_PACK;
                end else begin
                    m_d = m_q + 5'd1;
                end
            end

            ST_PACK: begin
                out_sign_d     = sign_q;
                out_zero_d     = 1'b0;
                out_nar_d      = 1'b0;
                out_k_d        = k_val;
                out_exp_d      = tail[28:25];
                out_frac_d     = tail[24:0];
                out_frac_len_d = frac_len_val;
`ifdef POSIT_DEC_SCALE_EN
                out_scale_d    = {k_val, 4'b0000} + {6'b000000, tail[28:25]};
`endif
                state_d        = ST_HOLD;
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            m_q            <= '0;
            body_q         <= '0;
            sign_q         <= 1'b0;
            out_sign_q     <= 1'b0;
            out_zero_q     <= 1'b0;
            out_nar_q      <= 1'b0;
            out_k_q        <= '0;
            out_exp_q      <= '0;
            out_frac_q     <= '0;
            out_frac_len_q <= '0;
`ifdef POSIT_DEC_SCALE_EN
            out_scale_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            body_q         <= body_d;
            sign_q         <= sign_d;
            out_sign_q     <= out_sign_d;
            out_zero_q     <= out_zero_d;
            out_nar_q      <= out_nar_d;
            out_k_q        <= out_k_d;
            out_exp_q      <= out_exp_d;
            out_frac_q     <= out_frac_d;
            out_frac_len_q <= out_frac_len_d;
`ifdef POSIT_DEC_SCALE_EN
            out_scale_q    <= out_scale_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_HOLD);
    assign out_sign     = out_sign_q;
    assign out_zero     = out_zero_q;
    assign out_nar      = out_nar_q;
    assign out_k        = out_k_q;
    assign out_exp      = out_exp_q;
    assign out_frac     = out_frac_q;
    assign out_frac_len = out_frac_len_q;
`ifdef POSIT_DEC_SCALE_EN
    assign out_scale    = out_scale_q;
`endif

endmodule : posit_decoder
